// File: rtl/seq_norm_trunc.sv
// Sequential leading-one normaliser and truncator with an optional denormalise pass.
// Reduces an operand to its top KEEP significant bits for the approximate arithmetic units.
module seq_norm_trunc #(
  parameter int WIDTH = 16,
  parameter int KEEP  = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             zero_flag,
  output logic [CNT_W-1:0] shamt,
  output logic [KEEP-1:0]  mant,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [2:0] {IDLE, NORM, TRUNC, DENORM, DONE} state_t;

  // Ones in the KEEP most significant positions; also correct when KEEP == WIDTH.
  localparam logic [WIDTH-1:0] KEEP_MASK = ~({WIDTH{1'b1}} >> KEEP);

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_wreg, w_wregNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic [CNT_W-1:0] r_rcnt, w_rcntNext;
  logic             r_modeQ;
  logic             r_zeroFlag;
  logic [CNT_W-1:0] r_shamt;
  logic [KEEP-1:0]  r_mant;
  logic [WIDTH-1:0] r_dout;
  logic             w_enterDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_wregNext  = r_wreg;
    w_cntNext   = r_cnt;
    w_rcntNext  = r_rcnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = NORM;
          w_wregNext  = din;
          w_cntNext   = '0;
        end
      end
      NORM: begin
        if (r_wreg == '0) begin
          w_stateNext = DONE;
        end else if (r_wreg[WIDTH-1]) begin
          w_stateNext = TRUNC;
        end else begin
          w_wregNext = r_wreg << 1;
          w_cntNext  = r_cnt + CNT_W'(1);
        end
      end
      TRUNC: begin
        w_wregNext  = r_wreg & KEEP_MASK;
        w_rcntNext  = r_cnt;
        w_stateNext = (!r_modeQ || r_cnt == '0) ? DONE : DENORM;
      end
      DENORM: begin
        w_wregNext = r_wreg >> 1;
        w_rcntNext = r_rcnt - CNT_W'(1);
        if (r_rcnt == CNT_W'(1)) w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_enterDone = (r_state != DONE) && (w_stateNext == DONE);

  // Results are loaded with the value wreg takes on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wreg     <= '0;
      r_cnt      <= '0;
      r_rcnt     <= '0;
      r_modeQ    <= 1'b0;
      r_zeroFlag <= 1'b0;
      r_shamt    <= '0;
      r_mant     <= '0;
      r_dout     <= '0;
    end else begin
      r_wreg <= w_wregNext;
      r_cnt  <= w_cntNext;
      r_rcnt <= w_rcntNext;
      if (r_state == IDLE && start) r_modeQ <= mode;
      if (r_state == TRUNC) r_mant <= r_wreg[WIDTH-1 -: KEEP];
      if (r_state == NORM && r_wreg == '0) r_mant <= '0;
      if (w_enterDone) begin
        r_dout     <= w_wregNext;
        r_shamt    <= r_cnt;
        r_zeroFlag <= (r_state == NORM) && (r_wreg == '0);
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign zero_flag = r_zeroFlag;
  assign shamt     = r_shamt;
  assign mant      = r_mant;
  assign dout      = r_dout;

endmodule

// File: tb/tb_seq_norm_trunc.sv
// Self-checking bench for seq_norm_trunc: directed and random operands, scoreboard
// of expected results and latencies, busy/done framing, ignored start, back-to-back and reset abort.
module tb_seq_norm_trunc;

  localparam int WIDTH = 16;
  localparam int KEEP  = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             zero_flag;
  logic [CNT_W-1:0] shamt;
  logic [KEEP-1:0]  mant;
  logic [WIDTH-1:0] dout;

  typedef struct {
    logic [CNT_W-1:0] shamt;
    logic [KEEP-1:0]  mant;
    logic [WIDTH-1:0] dout;
    logic             zero;
    int               lat;
  } exp_t;

  exp_t q[$];
  int   compCount = 0;
  int   errCount  = 0;
  int   cyc       = 0;
  int   startCyc  = 0;

  seq_norm_trunc #(.WIDTH(WIDTH), .KEEP(KEEP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
    .busy(busy), .done(done), .zero_flag(zero_flag),
    .shamt(shamt), .mant(mant), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic m);
    exp_t e;
    int lz;
    bit found;
    logic [WIDTH-1:0] n;
    lz = 0;
    found = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        lz = WIDTH - 1 - i;
        found = 1;
      end
    end
    if (d == '0) begin
      e.shamt = '0; e.mant = '0; e.dout = '0; e.zero = 1'b1; e.lat = 1;
    end else begin
      n = d << lz;
      e.mant = n[WIDTH-1 -: KEEP];
      n = n & 16'hFF00;
      e.dout = m ? (n >> lz) : n;
      e.shamt = CNT_W'(lz);
      e.zero = 1'b0;
      e.lat = (m && lz > 0) ? 2 * lz + 2 : lz + 2;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compCount++;
    assert (obs === expv) else begin
      errCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic driveStart(input logic [WIDTH-1:0] d, input logic m);
    q.push_back(model(d, m));
    @(negedge clk);
    start = 1'b1; din = d; mode = m;
    @(posedge clk); #1;
    startCyc = cyc;
    check("busy_after_accept", busy, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    exp_t e;
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    e = q.pop_front();
    if (seen) begin
      check("latency", cyc - startCyc, e.lat);
      check("shamt", shamt, e.shamt);
      check("mant", mant, e.mant);
      check("dout", dout, e.dout);
      check("zero_flag", zero_flag, e.zero);
      check("busy_in_done", busy, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("dout_hold", dout, e.dout);
    end
  endtask

  task automatic runOp(input logic [WIDTH-1:0] d, input logic m);
    driveStart(d, m);
    waitDone();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; din = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_shamt", shamt, 0);
    check("rst_mant", mant, 0);
    check("rst_zero", zero_flag, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    runOp(16'h0100, 1'b0);
    runOp(16'h01FF, 1'b1);
    runOp(16'h0000, 1'b0);
    runOp(16'h0000, 1'b1);
    runOp(16'h8001, 1'b1);
    runOp(16'h0001, 1'b1);

    // Second start while busy must not disturb the running operation.
    driveStart(16'h0100, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; din = 16'hFFFF; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    repeat (2) @(posedge clk);
    #1;
    check("ignored_start_idle", busy, 0);

    // Start held high: two back-to-back operations with one IDLE cycle between.
    q.push_back(model(16'h8001, 1'b1));
    q.push_back(model(16'h0003, 1'b0));
    @(negedge clk);
    start = 1'b1; din = 16'h8001; mode = 1'b1;
    @(posedge clk); #1;
    startCyc = cyc;
    @(negedge clk);
    din = 16'h0003; mode = 1'b0;
    waitDone();
    @(posedge clk); #1;
    startCyc = cyc;
    check("b2b_accept", busy, 1);
    @(negedge clk);
    start = 1'b0;
    waitDone();

    for (int k = 0; k < 6; k++) begin
      runOp(16'($urandom) >> $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    // Abort in the middle of the denormalise pass.
    runOp(16'h0300, 1'b0);
    @(negedge clk);
    start = 1'b1; din = 16'h01FF; mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_op_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dout", dout, 0);
    check("abort_shamt", shamt, 0);
    check("abort_mant", mant, 0);
    check("abort_zero", zero_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    runOp(16'h0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
